sram_cache_responder: RTL

- Memory-side responder for the CPU/cache request interface: serves one instruction-read port and one data read/write port from an internal word-addressed RAM.
- Returns single-cycle ok pulses and read data after a programmable latency.
- Used as the slave end of the CPU memory interface in block-level simulation and in cache-less builds.
- Handles one transaction at a time; data requests take priority over instruction requests.

---
 rtl/sram_cache_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sram_cache_responder.sv
// Word-addressed RAM slave for the CPU instruction/data request ports; one transaction at a time.
// Define SRAM_RESP_STATS_EN to build the completed-transaction counters on stat_*_o.
module sram_cache_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_ren_i,
  output logic        inst_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_ren_i,
  input  logic [3:0]  data_wen_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_read_ok_o,
  output logic        data_write_ok_o,
  output logic [31:0] data_rdata_o,
  input  logic        flush_i,
  output logic        busy_o,
  output logic [31:0] stat_inst_o,
  output logic [31:0] stat_rd_o,
  output logic [31:0] stat_wr_o,
  output logic [2:0]  state_o
);

  // Handshake: requests are levels sampled only in IDLE; completion is a one-cycle *_ok
  // pulse exactly LATENCY edges after the accept edge, followed by a RESP cycle in which
  // nothing is sampled, so a requester still holding its level is not re-accepted.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INST_WAIT = 3'd1,
    DRD_WAIT  = 3'd2,
    DWR_WAIT  = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            wen_q, wen_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  inst_ok_d, rd_ok_d, wr_ok_d;
  logic                  unused_addr_bits;

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

  assign unused_addr_bits = ^{inst_addr_i, data_addr_i};
  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    inst_ok_d = 1'b0;
    rd_ok_d   = 1'b0;
    wr_ok_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_ren_i) begin
          state_d = DRD_WAIT;
          addr_d  = data_addr_i[ADDR_WIDTH+1:2];
          wen_d   = 4'd0;
          cnt_d   = CNT_LOAD;
        end else if (data_wen_i != 4'd0) begin
          state_d = DWR_WAIT;
          addr_d  = data_addr_i[ADDR_WIDTH+1:2];
          wen_d   = data_wen_i;
          wdata_d = data_wdata_i;
          cnt_d   = CNT_LOAD;
        end else if (inst_ren_i) begin
          state_d = INST_WAIT;
          addr_d  = inst_addr_i[ADDR_WIDTH+1:2];
          cnt_d   = CNT_LOAD;
        end
      end
      INST_WAIT, DRD_WAIT: begin
        // A flush abandons a pending read outright, even on its completion edge.
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d   = RESP;
          inst_ok_d = (state_q == INST_WAIT);
          rd_ok_d   = (state_q == DRD_WAIT);
        end
      end
      DWR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          wr_ok_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      addr_q          <= '0;
      wen_q           <= 4'd0;
      wdata_q         <= 32'd0;
      inst_ok_o       <= 1'b0;
      data_read_ok_o  <= 1'b0;
      data_write_ok_o <= 1'b0;
      inst_rdata_o    <= 32'd0;
      data_rdata_o    <= 32'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      wen_q           <= wen_d;
      wdata_q         <= wdata_d;
      inst_ok_o       <= inst_ok_d;
      data_read_ok_o  <= rd_ok_d;
      data_write_ok_o <= wr_ok_d;
      if (inst_ok_d) inst_rdata_o <= mem[addr_q];
      if (rd_ok_d)   data_rdata_o <= mem[addr_q];
    end
  end

  // wr_ok_d derives from state_q, which reset forces to IDLE, so reset blocks the write.
  always_ff @(posedge clock_i) begin
    if (wr_ok_d) begin
      for (int b = 0; b < 4; b++) begin
        if (wen_q[b]) mem[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

`ifdef SRAM_RESP_STATS_EN
  logic [31:0] stat_inst_q, stat_rd_q, stat_wr_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      stat_inst_q <= 32'd0;
      stat_rd_q   <= 32'd0;
      stat_wr_q   <= 32'd0;
    end else begin
      if (inst_ok_d) stat_inst_q <= stat_inst_q + 32'd1;
      if (rd_ok_d)   stat_rd_q   <= stat_rd_q + 32'd1;
      if (wr_ok_d)   stat_wr_q   <= stat_wr_q + 32'd1;
    end
  end

  assign stat_inst_o = stat_inst_q;
  assign stat_rd_o   = stat_rd_q;
  assign stat_wr_o   = stat_wr_q;
`else
  assign stat_inst_o = 32'd0;
  assign stat_rd_o   = 32'd0;
  assign stat_wr_o   = 32'd0;
`endif

endmodule
